// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit (and future receive) datapath.
// Holds the frame FSM encoding, the even-parity helper and frame sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Parity helper input is fixed-width; callers zero-extend, which leaves the XOR unchanged.
    localparam int PARITY_MAX_W = 64;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

    localparam int DEFAULT_FRAME_BITS = frame_bits(8, 0, 1);

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; wraps every CLKS_PER_BIT cycles or when cleared.
// tick marks the last cycle of a bit period, tick_next the cycle before it.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PENULT_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick      = (count_q == LAST_CNT);
    assign tick_next = (count_q == PENULT_CNT);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples pre-edge values, independent of always_ff evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO (registered data_out) and serialises them
// as UART frames: start, LSB-first data, optional even parity, stop bit(s).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_req,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  rd_req_q, rd_req_d;
    logic                  frame_done_q, frame_done_d;

    logic start_ok;
    logic baud_clear;
    logic baud_tick;
    logic baud_tick_next;

    assign start_ok   = enable && !fifo_empty;
    assign baud_clear = (state_d != state_q);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .tick     (baud_tick),
        .tick_next(baud_tick_next)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                // FIFO data_out is valid now, one cycle after the read request.
                shift_d  = fifo_data;
                parity_d = even_parity(PARITY_MAX_W'(fifo_data));
                state_d  = START;
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = start_ok ? READ : IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the next state so their registered copies line up with state_q.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d       = (state_d != IDLE);
        rd_req_d     = (state_d == READ);
        frame_done_d = (state_q == STOP) && (bit_cnt_q == LAST_STOP_BIT) && baud_tick_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            rd_req_q     <= rd_req_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the shift/parity datapath is left unreset; it is always loaded in LATCH
    // before any state that drives it onto tx.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        parity_q <= parity_d;
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign fifo_rd_req = rd_req_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: lane 0 runs 8N1, lane 1 runs 8E1, both at 4 clocks per bit.
// Pushed words go to the expected queues; a per-lane UART monitor decodes tx and compares.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    enable;
    logic [1:0]    fifo_empty;
    logic [DW-1:0] fifo_data0;
    logic [DW-1:0] fifo_data1;
    logic [1:0]    fifo_rd_req;
    logic [1:0]    tx;
    logic [1:0]    busy;
    logic [1:0]    frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data0), .fifo_rd_req(fifo_rd_req[0]), .tx(tx[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data1), .fifo_rd_req(fifo_rd_req[1]), .tx(tx[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    int n_cmp = 0;
    int n_bad = 0;
    int frames[2];
    int rd_cnt[2];
    int gap_log[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int l, input logic [DW-1:0] d);
        if (l == 0) begin
            fq0.push_back(d);
            exp0.push_back(d);
        end else begin
            fq1.push_back(d);
            exp1.push_back(d);
        end
        fifo_empty[l] = 1'b0;
    endtask

    // FIFO models: pop on the read request, present the word before the LATCH edge.
    always @(negedge clk) begin
        if (fifo_rd_req[0] === 1'b1) begin
            rd_cnt[0]++;
            check("fifo0_underflow", 32'(fq0.size() == 0), 0);
            if (fq0.size() > 0) fifo_data0 = fq0.pop_front();
        end
        fifo_empty[0] = (fq0.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_req[1] === 1'b1) begin
            rd_cnt[1]++;
            check("fifo1_underflow", 32'(fq1.size() == 0), 0);
            if (fq1.size() > 0) fifo_data1 = fq1.pop_front();
        end
        fifo_empty[1] = (fq1.size() == 0);
    end

    // Decodes one frame whose first start-bit cycle is the current negedge sample.
    task automatic capture_frame(input int l, input int gap);
        int            nb;
        logic [15:0]   bits;
        logic [15:0]   eb;
        logic [DW-1:0] want;
        bit            timing_ok;
        bit            aborted;
        nb        = 2 + DW + l;
        bits      = '1;
        timing_ok = 1'b1;
        aborted   = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < CPB && !aborted; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (rst_n !== 1'b1) begin
                    aborted = 1'b1;
                end else begin
                    if (c == 0) bits[b] = tx[l];
                    else if (tx[l] !== bits[b]) timing_ok = 1'b0;
                    if (frame_done[l] !== ((b == nb - 1) && (c == CPB - 1))) timing_ok = 1'b0;
                    if (busy[l] !== 1'b1) timing_ok = 1'b0;
                end
            end
        end
        if (aborted) begin
            // The word in flight was already popped; reset discards it.
            if (l == 0 && exp0.size() > 0) void'(exp0.pop_front());
            if (l == 1 && exp1.size() > 0) void'(exp1.pop_front());
            return;
        end
        if ((l == 0 && exp0.size() == 0) || (l == 1 && exp1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame lane%0d: got bits 0x%0h, expected no frame", l, bits);
            return;
        end
        want = (l == 0) ? exp0.pop_front() : exp1.pop_front();
        eb = '1;
        eb[0] = 1'b0;
        eb[DW:1] = want;
        if (l == 1) eb[DW+1] = ^want;
        check($sformatf("frame_data_lane%0d", l), 32'(bits[DW:1]), 32'(want));
        check($sformatf("frame_bits_lane%0d", l), 32'(bits), 32'(eb));
        check($sformatf("frame_timing_lane%0d", l), 32'(timing_ok), 1);
        if (l == 0 && frames[0] < 16) gap_log[frames[0]] = gap;
        frames[l]++;
    endtask

    task automatic run_monitor(input int l);
        int idle = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                idle = 0;
            end else if (tx[l] === 1'b0) begin
                capture_frame(l, idle);
                idle = 0;
            end else begin
                idle++;
            end
        end
    endtask

    initial begin
        fork
            run_monitor(0);
            run_monitor(1);
        join_none
    end

    task automatic wait_frames(input int l, input int n, input int budget, input string name);
        int t = 0;
        while (frames[l] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, frames[l], n);
    endtask

    // Counts rising edges from the current negedge until tx is seen low.
    task automatic measure_latency(input int l, input string name);
        int lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (tx[l] === 1'b0) break;
        end
        check(name, lat, 3);
    endtask

    initial begin
        int bad;
        int cnt;
        int t;
        rst_n      = 1'b0;
        enable     = 2'b00;
        fifo_empty = 2'b11;
        fifo_data0 = '0;
        fifo_data1 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'h3);
        check("reset_busy", 32'(busy), 0);
        check("reset_rd_req", 32'(fifo_rd_req), 0);
        check("reset_frame_done", 32'(frame_done), 0);

        rst_n  = 1'b1;
        enable = 2'b11;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 2'b11 || busy !== 2'b00 || fifo_rd_req !== 2'b00) bad++;
        end
        check("idle_with_empty_fifo", bad, 0);

        // 0xA5, 8N1: one pop, 3-edge start latency, 40-cycle frame checked by the monitor.
        push(0, 8'hA5);
        measure_latency(0, "latency_a5");
        wait_frames(0, 1, 100, "frames_after_a5");
        check("rd_req_after_a5", rd_cnt[0], 1);

        // 0x07, 8E1: parity bit 1, busy spans READ+LATCH+44 = 46 cycles.
        @(negedge clk);
        push(1, 8'h07);
        cnt = 0;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            t++;
            if (busy[1] === 1'b1) cnt++;
            if (frames[1] >= 1 && busy[1] === 1'b0) break;
        end
        check("busy_cycles_parity_frame", cnt, 46);
        check("frames_parity_lane", frames[1], 1);
        check("rd_req_parity_lane", rd_cnt[1], 1);

        // Back-to-back 0x11, 0x22, 0x33: 2 high cycles between frames, busy never drops.
        @(negedge clk);
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        t = 0;
        while (busy[0] !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        cnt = 0;
        t = 0;
        while (frames[0] < 4 && t < 300) begin
            @(negedge clk);
            t++;
            if (frames[0] >= 4) break;
            if (busy[0] !== 1'b1) cnt++;
        end
        check("busy_low_during_burst", cnt, 0);
        check("frames_after_burst", frames[0], 4);
        check("gap_before_0x22", gap_log[2], 2);
        check("gap_before_0x33", gap_log[3], 2);
        check("rd_req_after_burst", rd_cnt[0], 4);

        // Enable dropped mid-frame: 0x44 completes, 0x55 stays in the FIFO.
        @(negedge clk);
        push(0, 8'h44);
        push(0, 8'h55);
        measure_latency(0, "latency_0x44");
        repeat (10) @(negedge clk);
        enable[0] = 1'b0;
        wait_frames(0, 5, 100, "frames_after_0x44");
        repeat (20) @(negedge clk);
        check("no_pop_while_disabled", rd_cnt[0], 5);
        check("word_held_in_fifo", 32'(fifo_empty[0]), 0);
        check("idle_while_disabled", 32'(busy[0]), 0);
        enable[0] = 1'b1;
        measure_latency(0, "latency_resume");
        wait_frames(0, 6, 100, "frames_after_0x55");
        check("rd_req_after_0x55", rd_cnt[0], 6);

        // Reset in DATA: 0x66 is lost, 0x77 follows cleanly.
        @(negedge clk);
        push(0, 8'h66);
        push(0, 8'h77);
        measure_latency(0, "latency_0x66");
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_frame_tx", 32'(tx[0]), 1);
        check("reset_mid_frame_busy", 32'(busy[0]), 0);
        rst_n = 1'b1;
        measure_latency(0, "latency_after_reset");
        wait_frames(0, 7, 100, "frames_after_0x77");
        check("rd_req_after_0x77", rd_cnt[0], 8);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp0.size() + exp1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
